// File: rtl/lpc_cycle_streamer_pkg.sv
// Shared types and constants for the LPC cycle-record streamer.
// Covers the serialiser state codes, the record type codes and the record field positions.
package lpc_cycle_streamer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_B3   = 3'd2,
        ST_B2   = 3'd3,
        ST_B1   = 3'd4,
        ST_B0   = 3'd5
    } strm_state_t;

    localparam int          REC_TYPE_MSB  = 1;
    localparam int          REC_TYPE_LSB  = 0;
    localparam logic [1:0]  REC_TYPE_NONE = 2'b00;

    // Byte shown on the stream for a given serialiser state; IDLE drives zero.
    function automatic logic [7:0] frame_byte(input strm_state_t st,
                                              input logic [31:0] rec,
                                              input logic [7:0]  sync);
        logic [7:0] b;
        b = 8'h00;
        case (st)
            ST_HDR:  b = sync;
            ST_B3:   b = rec[31:24];
            ST_B2:   b = rec[23:16];
            ST_B1:   b = rec[15:8];
            ST_B0:   b = rec[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/lpc_cycle_streamer_if.sv
// Byte stream (valid/ready) from the streamer to the host-side bridge.
interface lpc_cycle_streamer_if;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;

    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/lpc_cycle_streamer_fifo.sv
// Synchronous FIFO with level output; a push is accepted while full if a pop occurs on the same edge.
module lpc_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     nrst_i,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // The extra pointer bit separates a full FIFO from an empty one at equal indices.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/lpc_cycle_streamer.sv
// Captures LPC cycle records on READY rising edges, buffers them and serialises each
// as a sync byte plus four record bytes (MSB first) on a valid/ready byte stream.
module lpc_cycle_streamer
    import lpc_cycle_streamer_pkg::*;
#(
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
    input  logic                          clk_i,
    input  logic                          nrst_i,
    input  logic [31:0]                   tdata_i,
    input  logic                          ready_i,
    input  logic                          clear_i,
    lpc_cycle_streamer_if.master          strm,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic [7:0]                    drop_cnt_o,
    output logic                          overflow_o
);
    logic        ready_q;
    logic        keep_rec;
    logic        drop;
    logic        pop;
    logic        full;
    logic        empty;
    logic [31:0] head;
    logic        handshake;

    strm_state_t state_q, state_d;
    logic [31:0] shreg_q, shreg_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;

    assign keep_rec  = ready_i && !ready_q &&
                       (tdata_i[REC_TYPE_MSB:REC_TYPE_LSB] != REC_TYPE_NONE);
    assign drop      = keep_rec && full && !pop;
    assign handshake = valid_q && strm.m_ready;

    lpc_sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i  (clk_i),
        .nrst_i (nrst_i),
        .push   (keep_rec),
        .pop    (pop),
        .wdata  (tdata_i),
        .rdata  (head),
        .full   (full),
        .empty  (empty),
        .level  (fifo_level_o)
    );

    // History resets high so a READY already asserted at reset release is not a rising edge.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            ready_q    <= 1'b1;
            drop_cnt_o <= 8'h00;
            overflow_o <= 1'b0;
        end else begin
            ready_q <= ready_i;
            if (drop) begin
                overflow_o <= 1'b1;
                if (clear_i)                 drop_cnt_o <= 8'h01;
                else if (drop_cnt_o != 8'hFF) drop_cnt_o <= drop_cnt_o + 8'h01;
            end else if (clear_i) begin
                drop_cnt_o <= 8'h00;
                overflow_o <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q <= ST_IDLE;
            shreg_q <= 32'h0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    // Stream outputs are computed from the next state so they register alongside it.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: if (!empty) begin
                pop     = 1'b1;
                shreg_d = head;
                state_d = ST_HDR;
            end
            ST_HDR:  if (handshake) state_d = ST_B3;
            ST_B3:   if (handshake) state_d = ST_B2;
            ST_B2:   if (handshake) state_d = ST_B1;
            ST_B1:   if (handshake) state_d = ST_B0;
            ST_B0:   if (handshake) begin
                if (!empty) begin
                    pop     = 1'b1;
                    shreg_d = head;
                    state_d = ST_HDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        valid_d = (state_d != ST_IDLE);
        data_d  = frame_byte(state_d, shreg_d, SYNC_BYTE);
    end

    assign strm.m_data  = data_q;
    assign strm.m_valid = valid_q;

endmodule

// File: tb/tb_lpc_cycle_streamer.sv
// Directed self-checking bench for lpc_cycle_streamer: framing, backpressure, overflow, filtering, reset.
module tb_lpc_cycle_streamer;

    logic        clk_i = 1'b0;
    logic        nrst_i = 1'b0;
    logic [31:0] tdata_i = 32'h0;
    logic        ready_i = 1'b0;
    logic        clear_i = 1'b0;
    logic [3:0]  fifo_level_o;
    logic [7:0]  drop_cnt_o;
    logic        overflow_o;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  got[$];

    lpc_cycle_streamer_if strm_if ();

    lpc_cycle_streamer #(.FIFO_DEPTH(8), .SYNC_BYTE(8'hA5)) dut (
        .clk_i        (clk_i),
        .nrst_i       (nrst_i),
        .tdata_i      (tdata_i),
        .ready_i      (ready_i),
        .clear_i      (clear_i),
        .strm         (strm_if.master),
        .fifo_level_o (fifo_level_o),
        .drop_cnt_o   (drop_cnt_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    // Log every byte that will be accepted at the coming rising edge.
    initial begin
        strm_if.m_ready = 1'b0;
        forever begin
            @(negedge clk_i);
            #1;
            if (strm_if.m_valid && strm_if.m_ready) got.push_back(strm_if.m_data);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time exceeded");
        $fatal(1, "[TB] watchdog");
    end

    task automatic do_reset;
        nrst_i = 1'b0;
        ready_i = 1'b0;
        clear_i = 1'b0;
        tdata_i = 32'h0;
        strm_if.m_ready = 1'b0;
        repeat (2) @(negedge clk_i);
        nrst_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic send_rec(input logic [31:0] d);
        @(negedge clk_i);
        tdata_i = d;
        ready_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int budget, output bit timed_out);
        int cyc;
        cyc = 0;
        while (got.size() < n && cyc < budget) begin
            @(negedge clk_i);
            cyc++;
        end
        timed_out = (got.size() < n);
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if (strm_if.m_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_valid: got %b want 0", strm_if.m_valid); end
        checks++; if (strm_if.m_data !== 8'h00) begin failures++; $display("[TB] FAIL rst_data: got %h want 00", strm_if.m_data); end
        checks++; if (fifo_level_o !== 4'd0) begin failures++; $display("[TB] FAIL rst_level: got %0d want 0", fifo_level_o); end
        checks++; if (drop_cnt_o !== 8'h00) begin failures++; $display("[TB] FAIL rst_drop: got %h want 00", drop_cnt_o); end
        checks++; if (overflow_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_ovf: got %b want 0", overflow_o); end
    endtask

    task automatic test_single_frame;
        logic [7:0] exp_b[5] = '{8'hA5, 8'h00, 8'h08, 8'h05, 8'hA1};
        bit to;
        got.delete();
        strm_if.m_ready = 1'b1;
        @(negedge clk_i);
        tdata_i = 32'h0008_05A1;
        ready_i = 1'b1;
        @(negedge clk_i);
        checks++; if (strm_if.m_valid !== 1'b0) begin failures++; $display("[TB] FAIL t1_valid_e0: got %b want 0", strm_if.m_valid); end
        checks++; if (fifo_level_o !== 4'd1) begin failures++; $display("[TB] FAIL t1_level_e0: got %0d want 1", fifo_level_o); end
        @(negedge clk_i);
        checks++; if (strm_if.m_valid !== 1'b1) begin failures++; $display("[TB] FAIL t1_valid_e1: got %b want 1", strm_if.m_valid); end
        checks++; if (strm_if.m_data !== 8'hA5) begin failures++; $display("[TB] FAIL t1_sync_e1: got %h want a5", strm_if.m_data); end
        checks++; if (fifo_level_o !== 4'd0) begin failures++; $display("[TB] FAIL t1_level_e1: got %0d want 0", fifo_level_o); end
        ready_i = 1'b0;
        wait_bytes(5, 30, to);
        repeat (6) @(negedge clk_i);
        checks++; if (got.size() != 5) begin failures++; $display("[TB] FAIL t1_count: got %0d bytes want 5", got.size()); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp_b[i]) begin
                failures++;
                $display("[TB] FAIL t1_byte%0d: got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, exp_b[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] exp_b[5] = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h71};
        bit to;
        got.delete();
        strm_if.m_ready = 1'b1;
        send_rec(32'h1234_5671);
        wait_bytes(2, 30, to);
        checks++; if (to) begin failures++; $display("[TB] FAIL t2_wait2: got %0d bytes want 2", got.size()); end
        strm_if.m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            checks++; if (strm_if.m_valid !== 1'b1 || strm_if.m_data !== 8'h34) begin
                failures++;
                $display("[TB] FAIL t2_hold%0d: got valid=%b data=%h want valid=1 data=34", i, strm_if.m_valid, strm_if.m_data);
            end
        end
        strm_if.m_ready = 1'b1;
        wait_bytes(5, 30, to);
        repeat (4) @(negedge clk_i);
        checks++; if (got.size() != 5) begin failures++; $display("[TB] FAIL t2_count: got %0d bytes want 5", got.size()); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp_b[i]) begin
                failures++;
                $display("[TB] FAIL t2_byte%0d: got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, exp_b[i]);
            end
        end
    endtask

    // A primer record occupies the serialiser, so eight records fill the FIFO and three drop.
    task automatic test_overflow;
        logic [31:0] rec;
        logic [7:0]  eb;
        bit          to;
        do_reset();
        got.delete();
        send_rec(32'hCAFE_0001);
        for (int i = 0; i < 11; i++) send_rec(32'h0010_0003 | (32'(i) << 4));
        @(negedge clk_i);
        checks++; if (fifo_level_o !== 4'd8) begin failures++; $display("[TB] FAIL t3_level: got %0d want 8", fifo_level_o); end
        checks++; if (drop_cnt_o !== 8'd3) begin failures++; $display("[TB] FAIL t3_drop: got %0d want 3", drop_cnt_o); end
        checks++; if (overflow_o !== 1'b1) begin failures++; $display("[TB] FAIL t3_ovf: got %b want 1", overflow_o); end
        strm_if.m_ready = 1'b1;
        wait_bytes(45, 200, to);
        repeat (6) @(negedge clk_i);
        checks++; if (got.size() != 45) begin failures++; $display("[TB] FAIL t3_count: got %0d bytes want 45", got.size()); end
        for (int f = 0; f < 9; f++) begin
            rec = (f == 0) ? 32'hCAFE_0001 : (32'h0010_0003 | (32'(f - 1) << 4));
            for (int b = 0; b < 5; b++) begin
                case (b)
                    0: eb = 8'hA5;
                    1: eb = rec[31:24];
                    2: eb = rec[23:16];
                    3: eb = rec[15:8];
                    default: eb = rec[7:0];
                endcase
                checks++;
                if (f * 5 + b >= got.size() || got[f * 5 + b] !== eb) begin
                    failures++;
                    $display("[TB] FAIL t3_f%0d_b%0d: got %h want %h", f, b, (f * 5 + b < got.size()) ? got[f * 5 + b] : 8'hxx, eb);
                end
            end
        end
        checks++; if (fifo_level_o !== 4'd0) begin failures++; $display("[TB] FAIL t3_level_end: got %0d want 0", fifo_level_o); end
    endtask

    task automatic test_filter;
        @(negedge clk_i);
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        checks++; if (drop_cnt_o !== 8'd0 || overflow_o !== 1'b0) begin
            failures++; $display("[TB] FAIL t4_clear: got drop=%0d ovf=%b want 0/0", drop_cnt_o, overflow_o);
        end
        got.delete();
        strm_if.m_ready = 1'b1;
        send_rec(32'h0001_2340);
        repeat (8) @(negedge clk_i);
        checks++; if (got.size() != 0) begin failures++; $display("[TB] FAIL t4_none_frame: got %0d bytes want 0", got.size()); end
        checks++; if (drop_cnt_o !== 8'd0) begin failures++; $display("[TB] FAIL t4_none_drop: got %0d want 0", drop_cnt_o); end
        nrst_i = 1'b0;
        tdata_i = 32'h0005_5551;
        ready_i = 1'b1;
        @(negedge clk_i);
        nrst_i = 1'b1;
        repeat (8) @(negedge clk_i);
        checks++; if (got.size() != 0) begin failures++; $display("[TB] FAIL t4_rsthigh_frame: got %0d bytes want 0", got.size()); end
        checks++; if (fifo_level_o !== 4'd0) begin failures++; $display("[TB] FAIL t4_rsthigh_level: got %0d want 0", fifo_level_o); end
        checks++; if (strm_if.m_valid !== 1'b0) begin failures++; $display("[TB] FAIL t4_rsthigh_valid: got %b want 0", strm_if.m_valid); end
        ready_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_reset_midframe;
        logic [7:0] exp_b[5] = '{8'hA5, 8'h0A, 8'hBC, 8'hDE, 8'hF1};
        bit to;
        got.delete();
        strm_if.m_ready = 1'b1;
        send_rec(32'h8765_4321);
        wait_bytes(2, 30, to);
        nrst_i = 1'b0;
        #1;
        checks++; if (strm_if.m_valid !== 1'b0 || strm_if.m_data !== 8'h00) begin
            failures++; $display("[TB] FAIL t5_rst_out: got valid=%b data=%h want 0/00", strm_if.m_valid, strm_if.m_data);
        end
        checks++; if (fifo_level_o !== 4'd0) begin failures++; $display("[TB] FAIL t5_rst_level: got %0d want 0", fifo_level_o); end
        @(negedge clk_i);
        nrst_i = 1'b1;
        @(negedge clk_i);
        got.delete();
        send_rec(32'h0ABC_DEF1);
        wait_bytes(5, 30, to);
        repeat (6) @(negedge clk_i);
        checks++; if (got.size() != 5) begin failures++; $display("[TB] FAIL t5_count: got %0d bytes want 5", got.size()); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp_b[i]) begin
                failures++;
                $display("[TB] FAIL t5_byte%0d: got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, exp_b[i]);
            end
        end
    endtask

    task automatic test_drop_saturation;
        do_reset();
        for (int i = 0; i < 9 + 254; i++) send_rec(32'h0000_0013);
        @(negedge clk_i);
        checks++; if (drop_cnt_o !== 8'hFE) begin failures++; $display("[TB] FAIL t6_drop254: got %h want fe", drop_cnt_o); end
        send_rec(32'h0000_0013);
        @(negedge clk_i);
        checks++; if (drop_cnt_o !== 8'hFF) begin failures++; $display("[TB] FAIL t6_drop255: got %h want ff", drop_cnt_o); end
        for (int i = 0; i < 3; i++) send_rec(32'h0000_0013);
        @(negedge clk_i);
        checks++; if (drop_cnt_o !== 8'hFF) begin failures++; $display("[TB] FAIL t6_sat: got %h want ff", drop_cnt_o); end
        checks++; if (overflow_o !== 1'b1) begin failures++; $display("[TB] FAIL t6_ovf: got %b want 1", overflow_o); end
        @(negedge clk_i);
        tdata_i = 32'h0000_0013;
        ready_i = 1'b1;
        clear_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0;
        clear_i = 1'b0;
        checks++; if (drop_cnt_o !== 8'h01) begin failures++; $display("[TB] FAIL t6_clr_drop: got %h want 01", drop_cnt_o); end
        checks++; if (overflow_o !== 1'b1) begin failures++; $display("[TB] FAIL t6_clr_ovf: got %b want 1", overflow_o); end
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        checks++; if (drop_cnt_o !== 8'h00 || overflow_o !== 1'b0) begin
            failures++; $display("[TB] FAIL t6_clear: got drop=%h ovf=%b want 00/0", drop_cnt_o, overflow_o);
        end
        checks++; if (fifo_level_o !== 4'd8) begin failures++; $display("[TB] FAIL t6_level: got %0d want 8", fifo_level_o); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_overflow();
        test_filter();
        test_reset_midframe();
        test_drop_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
